// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dac_pkg
//  Brief    : Shared defaults and state encoding for the DAC feeder path.
//  Revision : 1.0
// ============================================================================
package dac_pkg;

    localparam int DAC_BW       = 14;
    localparam int DAC_OSR_LOG2 = 6;
    localparam int ST_W         = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STARVE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dac_interp_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dac_interp_feeder_if
//  Brief    : PCM sample valid/ready stream into the interpolating feeder.
//  Revision : 1.0
// ============================================================================
interface dac_interp_feeder_if
    import dac_pkg::*;
#(
    parameter int BW = DAC_BW
);

    logic [BW-1:0] s_data_i;
    logic          s_valid_i;
    logic          s_ready_o;

    modport master (
        output s_data_i,
        output s_valid_i,
        input  s_ready_o
    );

    modport slave (
        input  s_data_i,
        input  s_valid_i,
        output s_ready_o
    );

endinterface
`default_nettype wire

// File: rtl/dac_skid1.sv
`default_nettype none
// ============================================================================
//  Module   : dac_skid1
//  Brief    : One-entry sample holding register; ready is the registered empty flag.
//  Revision : 1.0
// ============================================================================
module dac_skid1
    import dac_pkg::*;
#(
    parameter int BW = DAC_BW
) (
    input  wire logic              clk_i,
    input  wire logic              rst_ni,
    dac_interp_feeder_if.slave     s,
    input  wire logic              i_consume,
    output logic        [BW-1:0]   o_nxt_data,
    output logic                   o_nxt_vld
);

    logic [BW-1:0] r_nxt;
    logic          r_nxt_vld;
    logic          w_xfer;

    // Ready never depends on valid in the same cycle; a consume and a
    // transfer cannot coincide because ready is low while the entry is full.
    assign s.s_ready_o = ~r_nxt_vld;
    assign w_xfer      = s.s_valid_i & ~r_nxt_vld;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_nxt     <= '0;
            r_nxt_vld <= 1'b0;
        end else if (w_xfer) begin
            r_nxt     <= s.s_data_i;
            r_nxt_vld <= 1'b1;
        end else if (i_consume) begin
            r_nxt_vld <= 1'b0;
        end
    end

    assign o_nxt_data = r_nxt;
    assign o_nxt_vld  = r_nxt_vld;

endmodule
`default_nettype wire

// File: rtl/dac_interp_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : dac_interp_feeder
//  Brief    : Linear-interpolating PCM feeder for the delta-sigma modulator input.
//  Revision : 1.0
// ============================================================================
module dac_interp_feeder
    import dac_pkg::*;
#(
    parameter int BW       = DAC_BW,
    parameter int OSR_LOG2 = DAC_OSR_LOG2
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_ni,
    dac_interp_feeder_if.slave        s,
    output logic signed [BW-1:0]      dac_o,
    output logic                      active_o,
    output logic                      underrun_o
);

    localparam int SW = BW + 1;
    localparam int AW = BW + OSR_LOG2 + 1;

    state_t                    r_state,    w_state_nxt;
    logic signed [BW-1:0]      r_tgt,      w_tgt_nxt;
    logic signed [SW-1:0]      r_step,     w_step_nxt;
    logic signed [AW-1:0]      r_acc,      w_acc_nxt;
    logic        [OSR_LOG2-1:0] r_phase,   w_phase_nxt;
    logic signed [BW-1:0]      r_dac,      w_dac_nxt;
    logic                      r_underrun, w_underrun_nxt;

    logic signed [BW-1:0]      w_nxt_data;
    logic                      w_nxt_vld;
    logic                      w_consume;
    logic signed [BW-1:0]      w_start;
    logic signed [SW-1:0]      w_step_load;
    logic signed [AW-1:0]      w_acc_sum;
    logic                      w_seg_end;

    dac_skid1 #(
        .BW (BW)
    ) u_skid (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .s          (s),
        .i_consume  (w_consume),
        .o_nxt_data (w_nxt_data),
        .o_nxt_vld  (w_nxt_vld)
    );

    // A new segment starts from 0 out of IDLE, otherwise from the previous target.
    // The BW+1-bit difference covers a full-scale swing without wrapping.
    assign w_start     = (r_state == ST_IDLE) ? '0 : r_tgt;
    assign w_step_load = {w_nxt_data[BW-1], w_nxt_data} - {w_start[BW-1], w_start};
    assign w_acc_sum   = r_acc + {{OSR_LOG2{r_step[SW-1]}}, r_step};
    assign w_seg_end   = &r_phase;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_tgt      <= '0;
            r_step     <= '0;
            r_acc      <= '0;
            r_phase    <= '0;
            r_dac      <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tgt      <= w_tgt_nxt;
            r_step     <= w_step_nxt;
            r_acc      <= w_acc_nxt;
            r_phase    <= w_phase_nxt;
            r_dac      <= w_dac_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_tgt_nxt      = r_tgt;
        w_step_nxt     = r_step;
        w_acc_nxt      = r_acc;
        w_phase_nxt    = r_phase;
        w_dac_nxt      = r_dac;
        w_underrun_nxt = 1'b0;
        w_consume      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_dac_nxt = '0;
                if (w_nxt_vld) begin
                    w_tgt_nxt   = w_nxt_data;
                    w_step_nxt  = w_step_load;
                    w_acc_nxt   = '0;
                    w_phase_nxt = '0;
                    w_consume   = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                // acc lands exactly on tgt<<OSR_LOG2 at the last step, so the
                // next segment continues from it with no drift.
                w_acc_nxt   = w_acc_sum;
                w_phase_nxt = r_phase + OSR_LOG2'(1);
                w_dac_nxt   = w_acc_sum[BW+OSR_LOG2-1:OSR_LOG2];
                if (w_seg_end) begin
                    if (w_nxt_vld) begin
                        w_tgt_nxt   = w_nxt_data;
                        w_step_nxt  = w_step_load;
                        w_phase_nxt = '0;
                        w_consume   = 1'b1;
                    end else begin
                        w_state_nxt    = ST_STARVE;
                        w_underrun_nxt = 1'b1;
                    end
                end
            end

            ST_STARVE: begin
                if (w_nxt_vld) begin
                    w_tgt_nxt   = w_nxt_data;
                    w_step_nxt  = w_step_load;
                    w_phase_nxt = '0;
                    w_consume   = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign dac_o      = r_dac;
    assign active_o   = (r_state == ST_RUN);
    assign underrun_o = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_dac_interp_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dac_interp_feeder
//  Brief    : Directed self-checking bench for dac_interp_feeder (BW=14, N=4).
//  Revision : 1.0
// ============================================================================
module tb_dac_interp_feeder;

    localparam int BW       = 14;
    localparam int OSR_LOG2 = 2;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    dac_interp_feeder_if #(.BW(BW)) s_if ();

    logic signed [BW-1:0] dac;
    logic                 active;
    logic                 underrun;

    dac_interp_feeder #(
        .BW       (BW),
        .OSR_LOG2 (OSR_LOG2)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .s          (s_if.slave),
        .dac_o      (dac),
        .active_o   (active),
        .underrun_o (underrun)
    );

    int n_cmp   = 0;
    int n_fail  = 0;
    int n_under = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (underrun) n_under++;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        s_if.s_valid_i = 1'b0;
        s_if.s_data_i  = '0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    // Two samples back to back with valid held; checks the eight output steps.
    task automatic two_seg(input string tag, input int a, input int b, input int e[8]);
        s_if.s_valid_i = 1'b1;
        s_if.s_data_i  = BW'(a);
        tick();                                  // first sample taken
        s_if.s_data_i  = BW'(b);
        chk({tag, "_ready_full"}, int'(s_if.s_ready_o), 0);
        tick();                                  // IDLE loads segment
        chk({tag, "_ready_free"}, int'(s_if.s_ready_o), 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) s_if.s_valid_i = 1'b0;   // second sample taken on this edge
            chk($sformatf("%s_dac%0d", tag, i), int'(dac), e[i]);
            if (i == 2) chk({tag, "_ready_held"}, int'(s_if.s_ready_o), 0);
            if (i == 3) chk({tag, "_no_underrun"}, int'(underrun), 0);
        end
        chk({tag, "_underrun_end"}, int'(underrun), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e8[8];
        int bp_end[6];
        int bp_idx;

        s_if.s_valid_i = 1'b0;
        s_if.s_data_i  = '0;

        // Reset values while reset is held low
        #1;
        chk("rst_dac",      int'(dac), 0);
        chk("rst_ready",    int'(s_if.s_ready_o), 1);
        chk("rst_active",   int'(active), 0);
        chk("rst_underrun", int'(underrun), 0);

        // Single sample 400 from IDLE, then starve and resume with 0
        do_reset();
        s_if.s_valid_i = 1'b1;
        s_if.s_data_i  = 14'd400;
        tick();
        s_if.s_valid_i = 1'b0;
        chk("s1_ready_full", int'(s_if.s_ready_o), 0);
        chk("s1_dac_idle",   int'(dac), 0);
        chk("s1_active_idle", int'(active), 0);
        tick();
        chk("s1_active_load", int'(active), 1);
        chk("s1_dac_load",    int'(dac), 0);
        n_under = 0;
        e8 = '{100, 200, 300, 400, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("s1_dac%0d", i), int'(dac), e8[i]);
        end
        chk("s1_underrun", int'(underrun), 1);
        chk("s1_active_drop", int'(active), 0);
        repeat (10) tick();
        chk("s1_hold", int'(dac), 400);
        chk("s1_hold_underrun", int'(underrun), 0);
        s_if.s_valid_i = 1'b1;
        s_if.s_data_i  = 14'd0;
        tick();
        s_if.s_valid_i = 1'b0;
        tick();
        chk("s1_resume_load", int'(dac), 400);
        chk("s1_resume_active", int'(active), 1);
        e8 = '{300, 200, 100, 0, 0, 0, 0, 0};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("s1_ramp%0d", i), int'(dac), e8[i]);
        end
        chk("s1_underrun_count", n_under, 1);
        tick();
        chk("s1_ramp3", int'(dac), 0);
        chk("s1_reenter_underrun", int'(underrun), 1);

        // Back-to-back 400, -400
        do_reset();
        e8 = '{100, 200, 300, 400, 200, 0, -200, -400};
        two_seg("b2b", 400, -400, e8);

        // Full-scale swing 8191 -> -8192
        do_reset();
        e8 = '{2047, 4095, 6143, 8191, 4095, -1, -4097, -8192};
        two_seg("fs", 8191, -8192, e8);

        // Reset mid-segment with a sample buffered
        do_reset();
        s_if.s_valid_i = 1'b1;
        s_if.s_data_i  = 14'd400;
        tick();
        s_if.s_data_i  = -14'sd400;
        tick();
        tick();
        s_if.s_valid_i = 1'b0;
        tick();
        chk("mr_dac_before", int'(dac), 200);
        rst_ni = 1'b0;
        #1;
        chk("mr_dac",    int'(dac), 0);
        chk("mr_ready",  int'(s_if.s_ready_o), 1);
        chk("mr_active", int'(active), 0);
        tick();
        chk("mr_dac_low", int'(dac), 0);
        rst_ni = 1'b1;
        repeat (6) tick();
        chk("mr_discard_dac",    int'(dac), 0);
        chk("mr_discard_active", int'(active), 0);

        // Backpressure: valid held 20 clocks, data 40*k before edge k.
        // Handshakes land on edges 1,3,7,11,15,19; segments end on 6,10,...,26.
        do_reset();
        bp_end = '{40, 120, 280, 440, 600, 760};
        bp_idx = 0;
        for (int k = 1; k <= 26; k++) begin
            if (k <= 20) begin
                s_if.s_valid_i = 1'b1;
                s_if.s_data_i  = BW'(40 * k);
            end else begin
                s_if.s_valid_i = 1'b0;
            end
            tick();
            if (k == 8) chk("bp_mid", int'(dac), 80);
            if (k == 6 || k == 10 || k == 14 || k == 18 || k == 22 || k == 26) begin
                chk($sformatf("bp_tgt%0d", bp_idx), int'(dac), bp_end[bp_idx]);
                bp_idx++;
            end
        end
        chk("bp_underrun", int'(underrun), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
